// File: rtl/instruction_fetch_if.sv
// Bundle between the fetch stage, its instruction memory and the decode stage.
// Redirect and stall arrive from later pipeline stages.
interface instruction_fetch_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  modport master (
    input  stall, redirect_valid, redirect_pc, imem_rdata,
    output imem_en, imem_addr, id_valid, id_instr, id_pc
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, imem_rdata,
    input  imem_en, imem_addr, id_valid, id_instr, id_pc
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage with IF/ID register: owns the PC, drives a one-cycle-latency
// instruction memory, and absorbs decode stalls with a one-entry skid buffer.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic               clk,
  input logic               rst,
  instruction_fetch_if.master bus
);

  logic [31:0] pc_q, pc_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] target;

  // Masking keeps every redirect target, and hence every issued address, word aligned.
  assign target = bus.redirect_pc & 32'hFFFF_FFFC;

  assign bus.imem_addr = bus.redirect_valid ? target : pc_q;
  assign bus.imem_en   = !rst && (bus.redirect_valid || !bus.stall);
  assign bus.id_valid  = id_valid_q;
  assign bus.id_instr  = id_instr_q;
  assign bus.id_pc     = id_pc_q;

  always_comb begin
    pc_d         = pc_q;
    req_valid_d  = req_valid_q;
    req_pc_d     = req_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_pc_d      = id_pc_q;

    if (bus.redirect_valid) begin
      req_pc_d     = target;
      req_valid_d  = 1'b1;
      pc_d         = target + 32'd4;
      skid_valid_d = 1'b0;
      id_valid_d   = 1'b0;
      id_instr_d   = 32'h0;
    end else if (bus.stall) begin
      // Reads are suppressed while stalled, so only the word already in flight can land here.
      req_valid_d = 1'b0;
      if (req_valid_q) begin
        skid_valid_d = 1'b1;
        skid_instr_d = bus.imem_rdata;
        skid_pc_d    = req_pc_q;
      end
    end else begin
      req_pc_d    = pc_q;
      req_valid_d = 1'b1;
      pc_d        = pc_q + 32'd4;
      if (skid_valid_q) begin
        skid_valid_d = 1'b0;
        id_valid_d   = 1'b1;
        id_instr_d   = skid_instr_q;
        id_pc_d      = skid_pc_q;
      end else if (req_valid_q) begin
        id_valid_d = 1'b1;
        id_instr_d = bus.imem_rdata;
        id_pc_d    = req_pc_q;
      end else begin
        id_valid_d = 1'b0;
        id_instr_d = 32'h0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      req_valid_q  <= 1'b0;
      req_pc_q     <= 32'h0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= 32'h0;
      skid_pc_q    <= 32'h0;
      id_valid_q   <= 1'b0;
      id_instr_q   <= 32'h0;
      id_pc_q      <= 32'h0;
    end else begin
      pc_q         <= pc_d;
      req_valid_q  <= req_valid_d;
      req_pc_q     <= req_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc_q      <= id_pc_d;
    end
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Front-end fetch stage and IF/ID pipeline register. It owns the program counter and drives a synchronous-read instruction memory with a one-cycle read latency. It delivers each 32-bit instruction word and its PC to the decode stage, which cracks the word into the 26-bit control word. It handles decode-stage stalls without losing in-flight data, and redirects from branch/jump resolution with a flush.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; must be word aligned.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: decode stage cannot accept a new instruction; IF/ID outputs hold.
- `redirect_valid` in 1: a taken branch/jump was resolved; fetch restarts at `redirect_pc`.
- `redirect_pc` in 32: target address; bits [1:0] ignored and treated as 0.
- `imem_en` out 1: read strobe to instruction memory.
- `imem_addr` out 32: byte address of the word being read; always word aligned.
- `imem_rdata` in 32: word for the address presented on the previous cycle with `imem_en`=1.
- `id_valid` out 1: `id_instr`/`id_pc` hold a real instruction.
- `id_instr` out 32: instruction word to the decoder.
- `id_pc` out 32: address of `id_instr`.

## Operation
- Internal state:
  - `pc_q`: next address to issue.
  - `req_valid_q`, `req_pc_q`: a read was issued last cycle, so `imem_rdata` is meaningful this cycle.
  - `skid_valid_q`, `skid_instr_q`, `skid_pc_q`: one-entry holding buffer.
  - IF/ID registers driving `id_valid`, `id_instr` and `id_pc`.
- Combinational memory outputs:
  - `imem_addr` = `redirect_valid` ? {`redirect_pc`[31:2],2'b00} : `pc_q`.
  - `imem_en` = !`rst` && (`redirect_valid` || !`stall`).
- Priority per cycle is rst > redirect > stall > normal.
- **Reset:**
  - `pc_q`←`RESET_PC`; `req_valid_q`←0; `skid_valid_q`←0.
  - `id_valid`←0, `id_instr`←0, `id_pc`←0.
- **Redirect** (overrides `stall`):
  - Issue a read at the target: `req_pc_q`←target, `req_valid_q`←1, `pc_q`←target+4.
  - Discard the in-flight `imem_rdata` and the skid entry: `skid_valid_q`←0.
  - Flush IF/ID: `id_valid`←0, `id_instr`←0.
- **Stall** (no redirect):
  - IF/ID holds.
  - No new read is issued: `req_valid_q`←0 and `pc_q` holds.
  - If `req_valid_q` is set, capture `imem_rdata`/`req_pc_q` into the skid buffer.
  - The skid buffer never overflows, because reads are suppressed while stalled; at most one word is in flight when a stall begins.
- **Normal** (no stall, no redirect):
  - Issue a read at `pc_q`: `req_pc_q`←`pc_q`, `req_valid_q`←1, `pc_q`←`pc_q`+4.
  - IF/ID load source, in priority order:
    - skid entry if `skid_valid_q` (then `skid_valid_q`←0);
    - else `imem_rdata`/`req_pc_q` if `req_valid_q`;
    - else a bubble (`id_valid`←0, `id_instr`←0).
- Arithmetic: PC increment is +4 modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- A bubble always carries `id_instr`=0. The all-zero word is not a no-op in this ISA, so consumers must qualify every use with `id_valid`.

## Timing
- Memory read latency is one cycle. Fetch-to-ID latency is 2 cycles: address issued in cycle T, data returned in T+1, visible on `id_*` in T+2.
- After reset deassertion (first cycle with `rst`=0 = C0), the first instruction (`RESET_PC`) appears on `id_*` at C2; `id_valid`=0 during C0–C1.
- Redirect asserted in cycle T:
  - `id_valid`=0 in T+1.
  - The target instruction appears in T+2.
  - Penalty is the instruction that was in IF/ID plus the squashed in-flight word.
- Stall released in cycle U (first cycle with `stall`=0):
  - The skid word appears on `id_*` in U+1.
  - The next sequential word appears in U+2.
  - No bubble and no duplicate.
- `stall` asserted in the same cycle as `redirect_valid`: the redirect wins and IF/ID is flushed.
- Reset mid-stream drops all in-flight and skid state. `imem_en`=0 while `rst`=1.

## Test plan
- **Reset, `RESET_PC`=0x100, no stall:** `id_pc` sequence 0x100, 0x104, 0x108 at C2, C3, C4 with `id_valid`=1, and `id_instr` equals the memory model contents.
- **Stall for 3 cycles while 0x108 is in ID:** `id_*` hold 0x108; `imem_en`=0 for 3 cycles; after release, 0x10C then 0x110 on consecutive cycles, none dropped or duplicated.
- **Redirect to 0x2002 while executing at 0x110:**
  - one cycle with `id_valid`=0 and `id_instr`=0;
  - `imem_addr`=0x2000 in the redirect cycle;
  - `id_pc`=0x2000 two cycles later, then 0x2004.
- **`redirect_valid` and `stall` asserted together (target 0x300):** flush occurs, and `id_pc`=0x300 two cycles later with `stall` low.
- **Redirect to 0xFFFF_FFF8:** `id_pc` sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- **`rst` pulsed for one cycle during an active stall with a full skid buffer:** all `id_*` outputs are 0, the skid contents are discarded, and fetch restarts at `RESET_PC` with the first valid output 2 cycles after release.
